// File: rtl/vga_pkg.sv
// Shared types, colour constants and framebuffer sizing helper for the VGA scanout path.
package vga_pkg;

  typedef logic [23:0] rgb888_t;

  localparam rgb888_t COLOR_BLACK       = 24'h000000;
  localparam rgb888_t UNDERFLOW_DEFAULT = 24'hFF00FF;

  // Number of visible pixels in one frame.
  function automatic int unsigned fb_pixels(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous prefetch FIFO for scanout pixels. A flush empties it in one cycle and
// takes priority over any push or pop in the same cycle. Push while full and pop while
// empty are ignored.
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  rgb888_t                  din,
  input  logic                     pop,
  output rgb888_t                  dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  rgb888_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           full;
  logic           push_en;
  logic           pop_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers and occupancy.
  always_comb begin
    push_en  = push & ~full & ~flush;
    pop_en   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vga_fb_scanout_arbiter.sv
// Shares a single-port framebuffer RAM between raster-order scanout prefetch (strict
// priority) and a host write port that uses the RAM's idle cycles.
//
// Host handshake: a write transfers on any cycle where host_valid & host_ready are both
// high; host_ready does not depend on host_valid, and the host must hold addr/data stable
// while host_valid is high and host_ready is low.
module vga_fb_scanout_arbiter
  import vga_pkg::*;
#(
  parameter int      H_ACTIVE        = 640,
  parameter int      V_ACTIVE        = 480,
  parameter int      ADDR_W          = 19,
  parameter int      FIFO_DEPTH      = 16,
  parameter int      MEM_RD_LAT      = 1,
  parameter rgb888_t UNDERFLOW_COLOR = UNDERFLOW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              screenend,
  input  logic              active,
  input  logic              pix_en,
  output logic [23:0]       color_out,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [23:0]       host_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic              underflow,
  input  logic              clear_underflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W+1)'(fb_pixels(H_ACTIVE, V_ACTIVE));
  localparam logic [CNT_W:0]  OCC_LIM = (CNT_W+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]     fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      discard_q, discard_d;
  logic [MEM_RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  rgb888_t               mem_wdata_q, mem_wdata_d;
  rgb888_t               color_q, color_d;
  logic                  underflow_q, underflow_d;

  logic                  fetch_req;
  logic                  host_acc;
  logic                  ret_vld;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  rgb888_t               fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occupancy;

  vga_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (screenend),
    .push  (fifo_push),
    .din   (mem_rdata),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Arbitration: scanout fetches whenever slots (queued + outstanding) remain.
  always_comb begin
    occupancy  = {1'b0, fifo_count} + {1'b0, inflight_q};
    fetch_req  = ~screenend & ({1'b0, fetch_addr_q} < PIX_LIM) & (occupancy < OCC_LIM);
    host_ready = ~fetch_req;
    host_acc   = host_valid & host_ready;
    ret_vld    = rd_vld_q[MEM_RD_LAT-1];
    fifo_push  = ret_vld & (discard_q == '0) & ~screenend;
    fifo_pop   = active & pix_en & ~screenend;
  end

  // Next-state for fetch counter, outstanding/discard counters and RAM strobes.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    inflight_d   = inflight_q;
    discard_d    = discard_q;
    rd_vld_d     = (rd_vld_q << 1) | MEM_RD_LAT'(mem_re_q);
    mem_re_d     = fetch_req;
    mem_we_d     = host_acc & ({1'b0, host_addr} < PIX_LIM);
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    if (fetch_req) begin
      mem_addr_d = fetch_addr_q;
    end else if (host_acc) begin
      mem_addr_d  = host_addr;
      mem_wdata_d = host_data;
    end

    case ({fetch_req, ret_vld})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    if (screenend) begin
      fetch_addr_d = '0;
      // Everything still outstanding after this cycle belongs to the old frame.
      discard_d    = inflight_q - CNT_W'(ret_vld);
    end else begin
      if (fetch_req) fetch_addr_d = fetch_addr_q + 1'b1;
      if (ret_vld && discard_q != '0) discard_d = discard_q - 1'b1;
    end
  end

  // Next-state for pixel output and sticky underflow flag.
  always_comb begin
    color_d     = color_q;
    underflow_d = underflow_q & ~clear_underflow;
    if (screenend || !active) begin
      color_d = COLOR_BLACK;
    end else if (pix_en) begin
      if (fifo_empty) begin
        color_d     = UNDERFLOW_COLOR;
        underflow_d = 1'b1;
      end else begin
        color_d = fifo_head;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= '0;
      inflight_q   <= '0;
      discard_q    <= '0;
      rd_vld_q     <= '0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      color_q      <= '0;
      underflow_q  <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      rd_vld_q     <= rd_vld_d;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      color_q      <= color_d;
      underflow_q  <= underflow_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign color_out = color_q;
  assign underflow = underflow_q;

endmodule
